// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the freq_gen square-wave generator.
package freq_gen_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/freq_gen_phase_timer.sv
// Loadable down-counter that times one phase; expire pulses when a loaded count runs out.
module phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // A load of N expires N+1 cycles later; load wins over a coincident expiry.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = load_val;
            active_d = 1'b1;
        end else if (clear) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign value  = cnt_q;
    assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator: H cycles high, H cycles low, for N pulses or forever.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] half_period,
    input  logic [CNT_W-1:0] pulse_count,
    output logic             fout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] edges_sent
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cfg_half_q, cfg_half_d;
    logic [CNT_W-1:0] cfg_pulses_q, cfg_pulses_d;
    logic [CNT_W-1:0] edges_q, edges_d;
    logic             fout_q, fout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             timer_load;
    logic             timer_clear;
    logic [CNT_W-1:0] timer_load_val;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expire;

    logic             start_ok;
    logic             start_bad;
    logic             more_pulses;

    // stop outranks start, so a simultaneous pair is neither accepted nor rejected.
    assign start_ok    = start && !stop && (half_period != '0);
    assign start_bad   = start && !stop && (half_period == '0);
    assign more_pulses = (cfg_pulses_q == '0) || (edges_q < cfg_pulses_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .clear    (timer_clear),
        .value    (timer_value),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cfg_half_q   <= '0;
            cfg_pulses_q <= '0;
            edges_q      <= '0;
            fout_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_half_q   <= cfg_half_d;
            cfg_pulses_q <= cfg_pulses_d;
            edges_q      <= edges_d;
            fout_q       <= fout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = HIGH;
            end
            HIGH: begin
                if (stop)              state_d = IDLE;
                else if (timer_expire) state_d = LOW;
            end
            LOW: begin
                if (stop)              state_d = IDLE;
                else if (timer_expire) state_d = more_pulses ? HIGH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of the next state, so fout rises with the HIGH entry.
    always_comb begin
        fout_d         = (state_d == HIGH);
        busy_d         = (state_d != IDLE);
        done_d         = 1'b0;
        err_d          = 1'b0;
        edges_d        = edges_q;
        cfg_half_d     = cfg_half_q;
        cfg_pulses_d   = cfg_pulses_q;
        timer_load     = 1'b0;
        timer_clear    = 1'b0;
        timer_load_val = cfg_half_q - CntOne;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cfg_half_d     = half_period;
                    cfg_pulses_d   = pulse_count;
                    edges_d        = CntOne;
                    timer_load     = 1'b1;
                    timer_load_val = half_period - CntOne;
                end else if (start_bad) begin
                    err_d = 1'b1;
                end
            end
            HIGH: begin
                if (stop) begin
                    timer_clear = 1'b1;
                end else if (timer_expire) begin
                    timer_load = 1'b1;
                end
            end
            LOW: begin
                if (stop) begin
                    timer_clear = 1'b1;
                end else if (timer_expire) begin
                    if (more_pulses) begin
                        timer_load = 1'b1;
                        edges_d    = edges_q + CntOne;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign fout       = fout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign edges_sent = edges_q;

    timer_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE) |-> (timer_value < cfg_half_q));

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen: cycle-count model plus directed scenarios.
module tb_freq_gen;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] half_period = '0;
    logic [W-1:0] pulse_count = '0;
    logic         fout, busy, done, err;
    logic [W-1:0] edges_sent;

    int checks = 0;
    int errors = 0;

    freq_gen #(
        .CNT_W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .pulse_count (pulse_count),
        .fout        (fout),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .edges_sent  (edges_sent)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: k counts cycles since the accepted start; fout is high in the first half
    // of every 2H window, a new edge starts each window, a finite run ends at k=2H*N+1.
    bit           m_run = 1'b0;
    int           m_h = 0;
    int           m_pc = 0;
    longint       m_k = 0;
    logic [W-1:0] exp_edges = '0;
    logic         exp_fout = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic         exp_err = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (!rst_n) begin
            m_run     = 1'b0;
            m_k       = 0;
            exp_edges = '0;
        end else if (!m_run) begin
            if (start && !stop) begin
                if (half_period == '0) begin
                    exp_err = 1'b1;
                end else begin
                    m_run     = 1'b1;
                    m_h       = int'(half_period);
                    m_pc      = int'(pulse_count);
                    m_k       = 1;
                    exp_edges = W'(1);
                end
            end
        end else if (stop) begin
            m_run = 1'b0;
        end else begin
            m_k++;
            if (m_pc != 0 && m_k == longint'(2 * m_h * m_pc) + 1) begin
                m_run    = 1'b0;
                exp_done = 1'b1;
            end else if ((m_k - 1) % longint'(2 * m_h) == 0) begin
                exp_edges = exp_edges + W'(1);
            end
        end
        exp_busy = m_run;
        if (m_run) exp_fout = ((m_k - 1) % longint'(2 * m_h)) < longint'(m_h);
        else       exp_fout = 1'b0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        check_val("fout", 32'(fout), 32'(exp_fout));
        check_val("busy", 32'(busy), 32'(exp_busy));
        check_val("done", 32'(done), 32'(exp_done));
        check_val("err", 32'(err), 32'(exp_err));
        check_val("edges_sent", 32'(edges_sent), 32'(exp_edges));
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", 32'(busy), 32'(0));
        @(negedge clk);
    endtask

    task automatic launch(input logic [W-1:0] h, input logic [W-1:0] n);
        half_period = h;
        pulse_count = n;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [11:0] pat;
        int          cnt, dones, diff, e0;
        logic        prev;

        #1 rst_n = 1'b0;
        #2;
        check_val("rst_fout", 32'(fout), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_edges", 32'(edges_sent), 32'(0));
        check_val("rst_done_err", 32'({done, err}), 32'(0));
        adv(2);
        rst_n = 1'b1;
        adv(1);

        // H=3, N=2: 111000111000 then done at cycle 13.
        launch(W'(3), W'(2));
        pat[11] = fout;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = fout;
        end
        check_val("s1_pattern", 32'(pat), 32'(12'b111000111000));
        @(negedge clk);
        check_val("s1_done", 32'(done), 32'(1));
        check_val("s1_edges", 32'(edges_sent), 32'(2));
        check_val("s1_busy", 32'(busy), 32'(0));
        // Start in the cycle right after done restarts the count at 1.
        launch(W'(3), W'(1));
        check_val("s1_restart_busy", 32'(busy), 32'(1));
        check_val("s1_restart_edges", 32'(edges_sent), 32'(1));
        wait_idle(50);

        // H=1 continuous for 20 cycles, then stop.
        launch(W'(1), W'(0));
        adv(19);
        check_val("s2_edges20", 32'(edges_sent), 32'(10));
        check_val("s2_fout20", 32'(fout), 32'(0));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("s2_stop_fout", 32'(fout), 32'(0));
        check_val("s2_stop_busy", 32'(busy), 32'(0));
        check_val("s2_stop_edges", 32'(edges_sent), 32'(10));
        adv(2);

        // H=0 is rejected with a single err pulse.
        launch(W'(0), W'(3));
        check_val("s3_err", 32'(err), 32'(1));
        check_val("s3_busy", 32'(busy), 32'(0));
        @(negedge clk);
        check_val("s3_err_once", 32'(err), 32'(0));
        check_val("s3_edges_kept", 32'(edges_sent), 32'(10));

        // start together with stop in IDLE does nothing.
        half_period = W'(3);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_val("s21_busy", 32'(busy), 32'(0));
        adv(1);

        // H=4, N=3; half_period changed and start re-pulsed mid-run.
        launch(W'(4), W'(3));
        adv(2);
        half_period = W'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        adv(4);
        check_val("s4_c8_fout", 32'(fout), 32'(0));
        check_val("s4_c8_edges", 32'(edges_sent), 32'(1));
        @(negedge clk);
        check_val("s4_c9_fout", 32'(fout), 32'(1));
        check_val("s4_c9_edges", 32'(edges_sent), 32'(2));
        wait_idle(100);

        // Reset during LOW of pulse 3 of 5.
        launch(W'(2), W'(5));
        adv(10);
        check_val("s5_pre_edges", 32'(edges_sent), 32'(3));
        check_val("s5_pre_fout", 32'(fout), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check_val("s5_rst_fout", 32'(fout), 32'(0));
        check_val("s5_rst_busy", 32'(busy), 32'(0));
        check_val("s5_rst_edges", 32'(edges_sent), 32'(0));
        adv(2);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_val("s5_no_done", 32'(dones), 32'(0));

        // Start honoured on the first edge after reset release.
        rst_n = 1'b0;
        adv(1);
        rst_n = 1'b1;
        launch(W'(1), W'(1));
        check_val("s27_busy", 32'(busy), 32'(1));
        check_val("s27_edges", 32'(edges_sent), 32'(1));
        wait_idle(20);

        // H=5 continuous: count fout rising edges over a gate window.
        launch(W'(5), W'(0));
        e0   = int'(edges_sent);
        prev = fout;
        cnt  = 0;
        repeat (100) begin
            @(negedge clk);
            if (fout === 1'b1 && prev === 1'b0) cnt++;
            prev = fout;
        end
        diff = int'(edges_sent) - e0;
        check_val("s6_gate_within1", 32'((cnt - diff <= 1) && (diff - cnt <= 1)), 32'(1));
        check_val("s6_edges101", 32'(edges_sent), 32'(11));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        adv(1);

        // Continuous H=1 long enough for edges_sent to wrap past 31.
        launch(W'(1), W'(0));
        adv(69);
        check_val("wrap_edges70", 32'(edges_sent), 32'(3));
        check_val("wrap_busy", 32'(busy), 32'(1));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        adv(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/freq_gen.md
FREQ_GEN -- requirements
Module: freq_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the half-period, pulse-count and edge-count fields.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin generating.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the current run.
REQ-006 The block SHALL have port half_period, input, CNT_W bits: length of the high phase and of the low phase, in clk cycles.
REQ-007 The block SHALL have port pulse_count, input, CNT_W bits: number of pulses to generate; 0 means run continuously.
REQ-008 The block SHALL have port fout, output, 1 bit: generated square wave, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: run in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a finite run completes.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-012 The block SHALL have port edges_sent, output, CNT_W bits: number of fout rising edges produced in the current or last run.

Function
REQ-013 The FSM SHALL have states IDLE, HIGH, LOW; every output SHALL be registered.
REQ-014 When the block is in IDLE and start=1 and half_period>=1 at cycle t, it SHALL latch half_period and pulse_count, enter HIGH, and drive fout=1, busy=1 and edges_sent=1 at t+1.
REQ-015 When the block is in IDLE and start=1 and half_period=0, it SHALL stay in IDLE, pulse err=1 for one cycle, and leave edges_sent unchanged.
REQ-016 HIGH SHALL last exactly H cycles (H = latched half_period), followed by LOW lasting exactly H cycles, giving a fout period of 2H and a 50% duty cycle.
REQ-017 At the end of LOW, if pulse_count=0 or edges_sent<pulse_count, the block SHALL re-enter HIGH and increment edges_sent in the same cycle that fout rises.
REQ-018 At the end of the final LOW (edges_sent=pulse_count), the next cycle SHALL show state IDLE, busy=0, done=1 for one cycle, fout=0, and edges_sent holding its final value.
REQ-019 When H=1, fout SHALL toggle every cycle with no idle gap between pulses.
REQ-020 stop=1 in HIGH or LOW SHALL force IDLE, fout=0 and busy=0 on the next cycle, with no done pulse and edges_sent frozen.
REQ-021 stop SHALL have priority over start; start and stop asserted together in IDLE SHALL do nothing.
REQ-022 start while busy SHALL be ignored; changes to half_period and pulse_count while busy SHALL have no effect until the next accepted start.
REQ-023 edges_sent SHALL wrap from 2^CNT_W-1 to 0 in continuous mode, with no other side effect.
REQ-024 A start accepted in the cycle directly after done SHALL begin a new run and restart edges_sent at 1.

Reset
REQ-025 While rst_n=0, the block SHALL hold state=IDLE, fout=0, busy=0, done=0, err=0, edges_sent=0, and clear the latched configuration and the phase timer.
REQ-026 A reset asserted mid-run SHALL abort immediately and asynchronously, and SHALL produce no done pulse after release.
REQ-027 The first start SHALL be honoured on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 Package freq_gen_pkg SHALL hold the state enumeration (IDLE, HIGH, LOW) and the default CNT_W constant.
REQ-029 The block SHALL contain one sub-module, phase_timer: a loadable CNT_W down-counter with load, value and expire-pulse ports, used for both the HIGH and the LOW phase.
REQ-030 The total RTL SHALL be within 120-400 lines.

Verification
REQ-031 Scenario: half_period=3, pulse_count=2, start pulse -> fout pattern 111000111000, then done at cycle 13 after start, edges_sent=2, busy=0.
REQ-032 Scenario: half_period=1, pulse_count=0, run 20 cycles, then stop -> fout alternates 1010..., edges_sent=10, fout=0 the cycle after stop, no done.
REQ-033 Scenario: half_period=0, start -> err=1 for exactly one cycle, busy stays 0, fout stays 0.
REQ-034 Scenario: start with half_period=4; change half_period to 2 mid-run and pulse start again -> period stays 8 cycles and the second start is ignored.
REQ-035 Scenario: assert rst_n=0 during the LOW phase of pulse 3 of 5 -> all outputs go to reset values immediately, and no done pulse occurs after release.
REQ-036 Scenario: loop the generator output to the team's edge-counter input with half_period=5 -> the counted edges match edges_sent over the gate window, within ±1.
